// File: rtl/control_cmd_dispatch_if.sv
// Purpose : bundles the byte-receiver input, the shared handler command bus and
//           the dispatcher status outputs into one port.
// Latency : none, wires only.
// Backpressure: none; rx_valid and cmd_enable are single-cycle strobes with no ready.
// Ports (signals):
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   cmd_data          byte forwarded to the handlers (shared bus)
//   cmd_enable        one-hot, one-cycle strobe per forwarded byte
//   cmd_done          per-handler completion pulse
//   cmd_abort         per-handler abort pulse
//   active_cmd/busy   selected handler index and command-in-progress flag
//   err_unknown/err_timeout  one-cycle error pulses
// Modports: master = dispatcher side, slave = receiver/handler side.
interface control_cmd_dispatch_if #(
  parameter int NUM_CMDS = 4,
  parameter int SEL_BITS = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [7:0]          cmd_data;
  logic [NUM_CMDS-1:0] cmd_enable;
  logic [NUM_CMDS-1:0] cmd_done;
  logic [NUM_CMDS-1:0] cmd_abort;
  logic [SEL_BITS-1:0] active_cmd;
  logic                busy;
  logic                err_unknown;
  logic                err_timeout;

  modport master (
    input  rx_data, rx_valid, cmd_done,
    output cmd_data, cmd_enable, cmd_abort, active_cmd, busy, err_unknown, err_timeout
  );

  modport slave (
    output rx_data, rx_valid, cmd_done,
    input  cmd_data, cmd_enable, cmd_abort, active_cmd, busy, err_unknown, err_timeout
  );
endinterface

// File: rtl/control_cmd_dispatch.sv
// Purpose : decodes an opcode byte from the UART receiver, selects one command
//           handler, forwards every following byte to it until it reports done,
//           and aborts the handler if the inter-byte watchdog expires.
// Latency : 1 cycle from rx_valid to cmd_enable / err_unknown; all outputs registered.
// Backpressure: none; every rx_valid byte is consumed in the cycle it arrives.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   io_bus       control_cmd_dispatch_if.master (rx byte in, handler bus out,
//                done in, abort out, busy/active_cmd/error status out)
module control_cmd_dispatch #(
  parameter int                    NUM_CMDS       = 4,
  parameter logic [NUM_CMDS*8-1:0] OPCODES        = {8'h72, 8'h62, 8'h46, 8'h4C},
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    SEL_BITS       = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  control_cmd_dispatch_if.master  io_bus
);

  // Counter is wide enough to hold TIMEOUT_CYCLES; keep at least one bit so a
  // disabled watchdog still elaborates cleanly.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DISPATCH = 1'b1
  } state_t;

  // Registered state and outputs
  state_t              r_state;
  logic [SEL_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_cmd_data;
  logic [NUM_CMDS-1:0] r_cmd_enable;
  logic [NUM_CMDS-1:0] r_cmd_abort;
  logic                r_err_unknown;
  logic                r_err_timeout;

  // Next-state values
  state_t              w_state_nxt;
  logic [SEL_BITS-1:0] w_active_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [7:0]          w_data_nxt;
  logic [NUM_CMDS-1:0] w_en_nxt;
  logic [NUM_CMDS-1:0] w_abort_nxt;
  logic                w_unk_nxt;
  logic                w_to_nxt;
  logic                w_take_op;

  // Opcode decode
  logic                w_dec_hit;
  logic [SEL_BITS-1:0] w_dec_idx;
  logic                w_done_sel;

  // Only the selected handler's done is meaningful; others are ignored.
  assign w_done_sel = io_bus.cmd_done[r_active];

  // Scan from the top down so the lowest matching index wins when the
  // opcode table contains duplicates.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (io_bus.rx_data == OPCODES[8*i +: 8]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = SEL_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_active      <= '0;
      r_cnt         <= '0;
      r_cmd_data    <= '0;
      r_cmd_enable  <= '0;
      r_cmd_abort   <= '0;
      r_err_unknown <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_active      <= w_active_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cmd_data    <= w_data_nxt;
      r_cmd_enable  <= w_en_nxt;
      r_cmd_abort   <= w_abort_nxt;
      r_err_unknown <= w_unk_nxt;
      r_err_timeout <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_cmd_data;
    w_en_nxt     = '0;
    w_abort_nxt  = '0;
    w_unk_nxt    = 1'b0;
    w_to_nxt     = 1'b0;
    w_take_op    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_take_op = io_bus.rx_valid;
      end

      S_DISPATCH: begin
        if (w_done_sel) begin
          // Completion wins over a coincident byte: that byte is treated as
          // the next opcode and never reaches the finishing handler.
          w_state_nxt = S_IDLE;
          w_take_op   = io_bus.rx_valid;
        end else if (io_bus.rx_valid) begin
          w_data_nxt         = io_bus.rx_data;
          w_en_nxt[r_active] = 1'b1;
          w_cnt_nxt          = '0;
        end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
          w_abort_nxt[r_active] = 1'b1;
          w_to_nxt              = 1'b1;
          w_state_nxt           = S_IDLE;
        end else if (r_cnt != CNT_MAX) begin
          // Saturate rather than wrap (only reachable with the watchdog off).
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Opcode handling shared by IDLE and same-cycle re-dispatch.
    if (w_take_op) begin
      if (w_dec_hit) begin
        w_active_nxt = w_dec_idx;
        w_state_nxt  = S_DISPATCH;
        w_cnt_nxt    = '0;
      end else begin
        w_unk_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  assign io_bus.cmd_data    = r_cmd_data;
  assign io_bus.cmd_enable  = r_cmd_enable;
  assign io_bus.cmd_abort   = r_cmd_abort;
  assign io_bus.active_cmd  = r_active;
  assign io_bus.busy        = (r_state == S_DISPATCH);
  assign io_bus.err_unknown = r_err_unknown;
  assign io_bus.err_timeout = r_err_timeout;

  // A handler must never see a byte and an abort in the same cycle.
  a_en_abort_excl : assert property (@(posedge clk) disable iff (reset)
    !(|(r_cmd_enable & r_cmd_abort)));

  a_en_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(r_cmd_enable));

endmodule
